// File: rtl/tod_pkg.sv
// tod_pkg: shared field-select codes, field limits and BCD helper for the time-of-day clock.
package tod_pkg;
  localparam logic [1:0] SEL_SEC  = 2'd0;
  localparam logic [1:0] SEL_MIN  = 2'd1;
  localparam logic [1:0] SEL_HOUR = 2'd2;
  localparam logic [5:0] MAX_SEC  = 6'd59;
  localparam logic [5:0] MAX_MIN  = 6'd59;
  localparam logic [4:0] MAX_HOUR = 5'd23;

  function automatic logic [7:0] bin6_to_bcd2(input logic [5:0] v);
    logic [3:0] t;
    t = (v >= 6'd60) ? 4'd6 : 4'(v / 6'd10);
    return {t, 4'(v - 6'(t) * 6'd10)};
  endfunction
endpackage

// File: rtl/tod_mod_counter.sv
// tod_mod_counter: modulo-N field counter with parallel load, increment enable and carry-out.
module tod_mod_counter #(
  parameter int N         = 60,
  parameter int W         = 6,
  parameter int RESET_VAL = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_inc,
  output logic [W-1:0] o_val,
  output logic         o_carry
);
  logic [W-1:0] r_val;

  assign o_val   = r_val;
  assign o_carry = i_inc && r_val == W'(N - 1);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_val <= W'(RESET_VAL);
    else if (i_load) r_val <= i_load_val;
    else if (i_inc) r_val <= o_carry ? '0 : r_val + 1'b1;
endmodule

// File: rtl/tod_clock_core.sv
// tod_clock_core: prescaled hh:mm:ss clock with synchronous set, 12/24h display, alarm and status pulses.
module tod_clock_core
  import tod_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 1,
  parameter int RESET_HOUR = 0,
  parameter int RESET_MIN  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_en,
  input  logic       mode_12h,
  input  logic       set_stb,
  input  logic [1:0] set_sel,
  input  logic [5:0] set_val,
  input  logic       alarm_en,
  input  logic [4:0] alarm_hour,
  input  logic [5:0] alarm_min,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       pm,
  output logic       tick,
  output logic       day_wrap,
  output logic       alarm_hit,
  output logic       set_err
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] r_presc;
  logic          r_tick, r_day_wrap, r_alarm_hit, r_set_err;
  logic [5:0]    w_sec, w_min, w_next_min;
  logic [4:0]    w_hour, w_next_hour, w_h12;
  logic          w_set_ok, w_adv, w_sec_c, w_min_c, w_hour_c, w_alarm;

  assign w_set_ok = set_stb && (set_sel == SEL_SEC  ? set_val <= MAX_SEC :
                                set_sel == SEL_MIN  ? set_val <= MAX_MIN :
                                set_sel == SEL_HOUR ? set_val <= {1'b0, MAX_HOUR} : 1'b0);
  assign w_adv    = run_en && r_presc == LAST && !w_set_ok;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_presc <= '0;
    else if (w_set_ok) r_presc <= '0;
    else if (run_en) r_presc <= r_presc == LAST ? '0 : r_presc + 1'b1;

  tod_mod_counter #(.N(60), .W(6), .RESET_VAL(0)) u_sec (
    .clk(clk), .rst_n(rst_n), .i_load(w_set_ok && set_sel == SEL_SEC), .i_load_val(set_val),
    .i_inc(w_adv), .o_val(w_sec), .o_carry(w_sec_c)
  );
  tod_mod_counter #(.N(60), .W(6), .RESET_VAL(RESET_MIN)) u_min (
    .clk(clk), .rst_n(rst_n), .i_load(w_set_ok && set_sel == SEL_MIN), .i_load_val(set_val),
    .i_inc(w_sec_c), .o_val(w_min), .o_carry(w_min_c)
  );
  tod_mod_counter #(.N(24), .W(5), .RESET_VAL(RESET_HOUR)) u_hour (
    .clk(clk), .rst_n(rst_n), .i_load(w_set_ok && set_sel == SEL_HOUR), .i_load_val(set_val[4:0]),
    .i_inc(w_min_c), .o_val(w_hour), .o_carry(w_hour_c)
  );

  // Alarm compares the post-advance time; out-of-range alarm inputs can never equal it.
  assign w_next_min  = w_min_c ? 6'd0 : w_min + 6'd1;
  assign w_next_hour = w_hour_c ? 5'd0 : w_min_c ? w_hour + 5'd1 : w_hour;
  assign w_alarm     = alarm_en && w_sec_c && w_next_min == alarm_min && w_next_hour == alarm_hour;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_tick      <= 1'b0;
      r_day_wrap  <= 1'b0;
      r_alarm_hit <= 1'b0;
      r_set_err   <= 1'b0;
    end else begin
      r_tick      <= w_adv;
      r_day_wrap  <= w_hour_c;
      r_alarm_hit <= w_alarm;
      r_set_err   <= set_stb && !w_set_ok;
    end

  assign w_h12     = w_hour == 5'd0 ? 5'd12 : w_hour > 5'd12 ? w_hour - 5'd12 : w_hour;
  assign hour_bcd  = bin6_to_bcd2({1'b0, mode_12h ? w_h12 : w_hour});
  assign min_bcd   = bin6_to_bcd2(w_min);
  assign sec_bcd   = bin6_to_bcd2(w_sec);
  assign pm        = w_hour >= 5'd12;
  assign tick      = r_tick;
  assign day_wrap  = r_day_wrap;
  assign alarm_hit = r_alarm_hit;
  assign set_err   = r_set_err;
endmodule

// File: tb/tb_tod_clock_core.sv
// tb_tod_clock_core: directed and random stimulus against a seconds-of-day reference model, two prescaler settings.
module tb_tod_clock_core;
  logic       clk = 1'b0, rst_n = 1'b1, run_en = 1'b0, mode_12h = 1'b0, set_stb = 1'b0, alarm_en = 1'b0;
  logic [1:0] set_sel = 2'd0;
  logic [5:0] set_val = 6'd0, alarm_min = 6'd0;
  logic [4:0] alarm_hour = 5'd0;
  logic [7:0] hb0, mb0, sb0, hb1, mb1, sb1;
  logic       pm0, tk0, dw0, ah0, er0, pm1, tk1, dw1, ah1, er1;
  logic [28:0] obs0, obs1;

  localparam int DV[2] = '{1, 4};
  localparam int RT[2] = '{7 * 3600 + 5 * 60, 23 * 3600 + 59 * 60};
  localparam logic [7:0] TH[4]  = '{8'd0, 8'd12, 8'd13, 8'd23};
  localparam logic [7:0] E12[4] = '{8'h12, 8'h12, 8'h01, 8'h11};
  localparam logic [7:0] E24[4] = '{8'h00, 8'h12, 8'h13, 8'h23};

  int t[2], p[2];
  bit etk[2], edw[2], eah[2], eer[2];
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  tod_clock_core #(.CLK_HZ(1), .TICK_HZ(1), .RESET_HOUR(7), .RESET_MIN(5)) u0 (
    .clk(clk), .rst_n(rst_n), .run_en(run_en), .mode_12h(mode_12h), .set_stb(set_stb),
    .set_sel(set_sel), .set_val(set_val), .alarm_en(alarm_en), .alarm_hour(alarm_hour),
    .alarm_min(alarm_min), .hour_bcd(hb0), .min_bcd(mb0), .sec_bcd(sb0), .pm(pm0),
    .tick(tk0), .day_wrap(dw0), .alarm_hit(ah0), .set_err(er0)
  );
  tod_clock_core #(.CLK_HZ(4), .TICK_HZ(1), .RESET_HOUR(23), .RESET_MIN(59)) u1 (
    .clk(clk), .rst_n(rst_n), .run_en(run_en), .mode_12h(mode_12h), .set_stb(set_stb),
    .set_sel(set_sel), .set_val(set_val), .alarm_en(alarm_en), .alarm_hour(alarm_hour),
    .alarm_min(alarm_min), .hour_bcd(hb1), .min_bcd(mb1), .sec_bcd(sb1), .pm(pm1),
    .tick(tk1), .day_wrap(dw1), .alarm_hit(ah1), .set_err(er1)
  );

  assign obs0 = {hb0, mb0, sb0, pm0, tk0, dw0, ah0, er0};
  assign obs1 = {hb1, mb1, sb1, pm1, tk1, dw1, ah1, er1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic logic [28:0] expv(input int k);
    int h, hd;
    h  = t[k] / 3600;
    hd = mode_12h ? (h % 12 == 0 ? 12 : h % 12) : h;
    return {bcd(hd), bcd((t[k] / 60) % 60), bcd(t[k] % 60), h >= 12, etk[k], edw[k], eah[k], eer[k]};
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      t[k] = RT[k];
      p[k] = 0;
      {etk[k], edw[k], eah[k], eer[k]} = 4'b0;
    end
  endfunction

  function automatic void model_step(input int k);
    int h, m, s, lim;
    bit ok, wrap;
    h    = t[k] / 3600;
    m    = (t[k] / 60) % 60;
    s    = t[k] % 60;
    lim  = set_sel == 2'd2 ? 23 : 59;
    ok   = set_stb && set_sel != 2'd3 && int'(set_val) <= lim;
    wrap = run_en && p[k] == DV[k] - 1;
    {etk[k], edw[k], eah[k]} = 3'b0;
    eer[k] = set_stb && !ok;
    if (ok) begin
      p[k] = 0;
      if (set_sel == 2'd0) s = int'(set_val);
      else if (set_sel == 2'd1) m = int'(set_val);
      else h = int'(set_val);
      t[k] = h * 3600 + m * 60 + s;
    end else begin
      if (run_en) p[k] = wrap ? 0 : p[k] + 1;
      if (wrap) begin
        t[k]   = (t[k] + 1) % 86400;
        etk[k] = 1'b1;
        edw[k] = t[k] == 0;
        eah[k] = alarm_en && alarm_hour <= 5'd23 && alarm_min <= 6'd59 &&
                 t[k] == int'(alarm_hour) * 3600 + int'(alarm_min) * 60;
      end
    end
  endfunction

  task automatic cyc(input bit r, input bit stb, input logic [1:0] sel, input logic [5:0] val);
    run_en  = r;
    set_stb = stb;
    set_sel = sel;
    set_val = val;
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    check("dut0", 32'(obs0), 32'(expv(0)));
    check("dut1", 32'(obs1), 32'(expv(1)));
    set_stb = 1'b0;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    set_stb = 1'b1;
    set_sel = 2'd2;
    set_val = 6'd5;
    model_reset();
    #1;
    check("rst0", 32'(obs0), 32'(expv(0)));
    check("rst1", 32'(obs1), 32'(expv(1)));
    @(posedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    set_stb = 1'b0;
  endtask

  initial begin
    int nt;
    #2;
    do_reset();
    check("rst_time", 32'({hb0, mb0, sb0}), 32'h070500);
    check("rst_flags", 32'({pm0, tk0, dw0, ah0, er0}), 32'h0);
    cyc(0, 0, 2'd0, 6'd0);
    check("frozen", 32'({hb0, mb0, sb0}), 32'h070500);
    cyc(0, 1, 2'd2, 6'd23);
    cyc(0, 1, 2'd1, 6'd59);
    cyc(0, 1, 2'd0, 6'd58);
    cyc(1, 0, 2'd0, 6'd0);
    check("roll_s59", 32'({hb0, mb0, sb0, tk0}), {7'd0, 24'h235959, 1'b1});
    cyc(1, 0, 2'd0, 6'd0);
    check("roll_time", 32'({hb0, mb0, sb0}), 32'h000000);
    check("roll_dw", 32'({tk0, dw0}), 32'h3);
    cyc(0, 0, 2'd0, 6'd0);
    check("roll_dw_clr", 32'(dw0), 32'h0);
    cyc(0, 1, 2'd0, 6'd0);
    cyc(1, 0, 2'd0, 6'd0);
    cyc(1, 0, 2'd0, 6'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 2'd0, 6'd0);
      check("frz_tick", 32'(tk1), 32'h0);
    end
    cyc(1, 0, 2'd0, 6'd0);
    check("pre3", 32'({sb1, tk1}), 32'h0);
    cyc(1, 0, 2'd0, 6'd0);
    check("pre4", 32'({sb1, tk1}), {23'd0, 8'h01, 1'b1});
    cyc(0, 1, 2'd2, 6'd24);
    check("err_pulse", 32'(er0), 32'h1);
    check("err_time", 32'({hb0, mb0, sb0}), 32'h000004);
    cyc(1, 1, 2'd1, 6'd30);
    check("set_tick", 32'({mb0, sb0, tk0}), {15'd0, 16'h3004, 1'b0});
    for (int i = 0; i < 4; i++) cyc(1, 0, 2'd0, 6'd0);
    cyc(0, 1, 2'd3, 6'd1);
    check("sel11_err", 32'(er0), 32'h1);
    for (int i = 0; i < 4; i++) begin
      mode_12h = 1'b1;
      cyc(0, 1, 2'd2, 6'(TH[i]));
      check("h12", 32'({hb0, pm0}), {23'd0, E12[i], TH[i] >= 8'd12});
      mode_12h = 1'b0;
      cyc(0, 0, 2'd0, 6'd0);
      check("h24", 32'(hb0), 32'(E24[i]));
    end
    alarm_hour = 5'd6;
    alarm_min  = 6'd30;
    alarm_en   = 1'b1;
    cyc(0, 1, 2'd2, 6'd6);
    cyc(0, 1, 2'd1, 6'd29);
    cyc(0, 1, 2'd0, 6'd59);
    cyc(1, 0, 2'd0, 6'd0);
    check("alarm_hit", 32'({hb0, mb0, sb0, ah0}), {7'd0, 24'h063000, 1'b1});
    cyc(0, 0, 2'd0, 6'd0);
    check("alarm_clr", 32'(ah0), 32'h0);
    cyc(0, 1, 2'd1, 6'd29);
    cyc(0, 1, 2'd1, 6'd30);
    check("alarm_set", 32'({mb0, sb0, ah0}), {15'd0, 16'h3000, 1'b0});
    alarm_en = 1'b0;
    cyc(0, 1, 2'd1, 6'd29);
    cyc(0, 1, 2'd0, 6'd59);
    cyc(1, 0, 2'd0, 6'd0);
    check("alarm_off", 32'({mb0, sb0, ah0}), {15'd0, 16'h3000, 1'b0});
    for (int i = 0; i < 4000; i++) begin
      if (i % 700 == 699) do_reset();
      if ($urandom % 2 == 0) begin
        nt         = (t[0] / 60 + 1) % 1440;
        alarm_hour = 5'(nt / 60);
        alarm_min  = 6'(nt % 60);
      end else begin
        alarm_hour = 5'($urandom_range(0, 31));
        alarm_min  = 6'($urandom_range(0, 63));
      end
      mode_12h = 1'($urandom);
      alarm_en = $urandom % 4 != 0;
      cyc($urandom % 5 != 0, $urandom % 8 == 0, 2'($urandom), 6'($urandom_range(0, 63)));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
